// File: rtl/bb_core_pkg.sv
// Shared encodings for the bb_core processor: opcodes, memory actions, FSM states
// and instruction field positions as functions of the data width.
package bb_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ACT_IDLE = 2'b00;
  localparam logic [1:0] ACT_RD   = 2'b01;
  localparam logic [1:0] ACT_WR   = 2'b10;

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;

  function automatic int op_lsb(input int w);
    return w - 4;
  endfunction

  function automatic int rd_lsb(input int w);
    return w - 7;
  endfunction

  function automatic int rs_lsb(input int w);
    return w - 10;
  endfunction

  function automatic int imm_msb(input int w);
    return w - 8;
  endfunction

endpackage

// File: rtl/bb_regfile.sv
// Eight-entry register file: two combinational read ports, one write port,
// write takes effect on the rising edge; asynchronous reset clears all entries.
module bb_regfile #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            ra_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  input  logic [2:0]            rb_addr,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] regs [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/bb_core_hs.sv
// Multi-cycle fetch/execute core with one memory port; 2 cycles per instruction, 3 for LD/ST.
// Requests are held stable until i_ready=1, each low i_ready cycle adds one cycle.
module bb_core_hs
  import bb_core_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic [1:0]            o_action,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_halted,
  output logic                  o_illegal
);

  localparam int OP_LSB  = op_lsb(DATA_WIDTH);
  localparam int RD_LSB  = rd_lsb(DATA_WIDTH);
  localparam int RS_LSB  = rs_lsb(DATA_WIDTH);
  localparam int IMM_MSB = imm_msb(DATA_WIDTH);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc, pc_nxt;
  logic [DATA_WIDTH-1:0] ir;
  logic                  ir_load, illegal, set_illegal;
  logic [3:0]            op;
  logic [2:0]            rd, rs;
  logic [DATA_WIDTH-1:0] imm, rd_val, rs_val, alu, wr_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] rs_addr;
  logic [1:0]            action;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  halted;

  assign op      = ir[OP_LSB +: 4];
  assign rd      = ir[RD_LSB +: 3];
  assign rs      = ir[RS_LSB +: 3];
  assign imm     = DATA_WIDTH'(ir[IMM_MSB:0]);
  assign rs_addr = ADDR_WIDTH'(rs_val);

  bb_regfile #(.DATA_WIDTH(DATA_WIDTH)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (rd),
    .ra_data (rd_val),
    .rb_addr (rs),
    .rb_data (rs_val),
    .wr_en   (wr_en),
    .wr_addr (rd),
    .wr_data (wr_data)
  );

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = rd_val + rs_val;
      OP_SUB:  alu = rd_val - rs_val;
      OP_AND:  alu = rd_val & rs_val;
      OP_OR:   alu = rd_val | rs_val;
      OP_XOR:  alu = rd_val ^ rs_val;
      default: alu = '0;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    ir_load     = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    set_illegal = 1'b0;
    action      = ACT_IDLE;
    addr        = '0;
    data        = '0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        action = ACT_RD;
        addr   = pc;
        if (i_ready) begin
          ir_load   = 1'b1;
          pc_nxt    = pc + ADDR_WIDTH'(1);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        state_nxt = FETCH;
        case (op)
          OP_NOP: ;
          OP_LDI: begin
            wr_en   = 1'b1;
            wr_data = imm;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            wr_en   = 1'b1;
            wr_data = alu;
          end
          // pc already points past this instruction; a taken jump replaces it
          OP_JMP: pc_nxt = rs_addr;
          OP_BZ:  if (rd_val == '0) pc_nxt = rs_addr;
          OP_LD, OP_ST: state_nxt = MEM;
          OP_HALT: state_nxt = HALTED;
          default: set_illegal = 1'b1;
        endcase
      end
      MEM: begin
        addr = rs_addr;
        if (op == OP_ST) begin
          action = ACT_WR;
          data   = rd_val;
        end else begin
          action = ACT_RD;
        end
        if (i_ready) begin
          wr_en     = (op == OP_LD);
          wr_data   = i_data;
          state_nxt = FETCH;
        end
      end
      HALTED: halted = 1'b1;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ir_load) ir <= i_data;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // reset drops the bus request immediately, even though state resets to FETCH
  assign o_action  = rst ? ACT_IDLE : action;
  assign o_addr    = rst ? '0 : addr;
  assign o_data    = rst ? '0 : data;
  assign o_pc      = pc;
  assign o_halted  = halted;
  assign o_illegal = illegal;

endmodule

// File: tb/tb_bb_core_hs.sv
// Directed bench for bb_core_hs: table of ALU programs plus hand sequences for
// wait states, branches, illegal opcodes, reset abort and PC wrap.
module tb_bb_core_hs;
  import bb_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_ready = 1'b0;
  logic [1:0]  o_action;
  logic [15:0] o_addr, o_data, o_pc;
  logic        o_halted, o_illegal;

  logic        rst2 = 1'b1;
  logic [15:0] i_data2 = '0;
  logic        i_ready2 = 1'b0;
  logic [1:0]  o_action2;
  logic [3:0]  o_addr2, o_pc2;
  logic [15:0] o_data2;
  logic        o_halted2, o_illegal2;

  always #5 clk = ~clk;

  bb_core_hs #(.DATA_WIDTH(16), .ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .i_ready(i_ready),
    .o_action(o_action), .o_addr(o_addr), .o_data(o_data), .o_pc(o_pc),
    .o_halted(o_halted), .o_illegal(o_illegal)
  );

  bb_core_hs #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RESET_PC(4'd15)) dut2 (
    .clk(clk), .rst(rst2), .i_data(i_data2), .i_ready(i_ready2),
    .o_action(o_action2), .o_addr(o_addr2), .o_data(o_data2), .o_pc(o_pc2),
    .o_halted(o_halted2), .o_illegal(o_illegal2)
  );

  int total = 0;
  int bad = 0;
  logic [15:0] mem [256];
  logic [15:0] rd_q[$];
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int  wr_cycles;
  bit  stable_err, odata_err, rsvd_err;

  typedef struct {
    logic [3:0]  op;
    logic [8:0]  a;
    logic [8:0]  b;
    logic [2:0]  rs;
    logic [15:0] exp;
  } alu_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    return {op, rd, rs, 6'b000000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [8:0] imm);
    return {OP_LDI, rd, imm};
  endfunction

  function automatic logic [15:0] qat(input logic [15:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 16'hxxxx;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_ready = 1'b0;
    i_data = '0;
    @(negedge clk);
    rd_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cycles = 0;
    stable_err = 1'b0;
    odata_err = 1'b0;
    rsvd_err = 1'b0;
  endtask

  // Memory model: stall_n low-ready cycles before every completed transfer.
  task automatic run(input int stall_n, input int max_cyc, input bit expect_halt, output int cyc);
    int sc;
    logic [1:0]  pa;
    logic [15:0] pad;
    sc = 0;
    cyc = 0;
    pa = '0;
    pad = '0;
    rst = 1'b0;
    #1;
    while (!o_halted && cyc < max_cyc) begin
      if (o_action == 2'b11) rsvd_err = 1'b1;
      if (o_action != ACT_WR && o_data != '0) odata_err = 1'b1;
      if (o_action == ACT_IDLE) begin
        i_ready = 1'b1;
        i_data = 16'(($urandom));
      end else begin
        if (sc > 0 && (o_action != pa || o_addr != pad)) stable_err = 1'b1;
        pa = o_action;
        pad = o_addr;
        if (o_action == ACT_WR) wr_cycles++;
        if (sc < stall_n) begin
          i_ready = 1'b0;
          i_data = 16'(($urandom));
          sc++;
        end else begin
          i_ready = 1'b1;
          sc = 0;
          if (o_action == ACT_RD) begin
            i_data = mem[o_addr[7:0]];
            rd_q.push_back(o_addr);
          end else begin
            mem[o_addr[7:0]] = o_data;
            wr_addr_q.push_back(o_addr);
            wr_data_q.push_back(o_data);
          end
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (expect_halt) chk("halt_reached", 32'(o_halted), 32'd1);
  endtask

  task automatic load_ldst();
    clear_mem();
    mem[0] = ldi(1, 9'd5);
    mem[1] = ldi(2, 9'd3);
    mem[2] = ins(OP_ADD, 1, 2);
    mem[3] = ldi(3, 9'h20);
    mem[4] = ins(OP_ST, 1, 3);
    mem[5] = ins(OP_LD, 4, 3);
    mem[6] = ldi(5, 9'h21);
    mem[7] = ins(OP_ST, 4, 5);
    mem[8] = ins(OP_HALT, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_vec_t vt[8];
    int c;

    vt[0] = '{OP_ADD, 9'd5,    9'd3,    3'd2, 16'h0008};
    vt[1] = '{OP_SUB, 9'd2,    9'd5,    3'd2, 16'hFFFD};
    vt[2] = '{OP_AND, 9'h1F0,  9'h0FF,  3'd2, 16'h00F0};
    vt[3] = '{OP_OR,  9'h100,  9'h011,  3'd2, 16'h0111};
    vt[4] = '{OP_XOR, 9'h1FF,  9'h0F0,  3'd2, 16'h010F};
    vt[5] = '{OP_ADD, 9'h1FF,  9'h1FF,  3'd2, 16'h03FE};
    vt[6] = '{OP_ADD, 9'd7,    9'd100,  3'd1, 16'h000E};
    vt[7] = '{OP_SUB, 9'h123,  9'd1,    3'd1, 16'h0000};

    // reset values
    do_reset();
    chk("rst_action", 32'(o_action), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    chk("rst_illegal", 32'(o_illegal), 32'd0);
    chk("rst_pc", 32'(o_pc), 32'd0);

    // basic program, halt at cycle 8 and stay halted
    clear_mem();
    mem[0] = ldi(1, 9'd5);
    mem[1] = ldi(2, 9'd3);
    mem[2] = ins(OP_ADD, 1, 2);
    mem[3] = ins(OP_HALT, 0, 0);
    rst = 1'b0;
    #1;
    chk("first_fetch_action", 32'(o_action), 32'(ACT_RD));
    chk("first_fetch_addr", 32'(o_addr), 32'd0);
    run(0, 100, 1'b1, c);
    chk("basic_cycles", 32'(c), 32'd8);
    repeat (5) @(negedge clk);
    chk("hold_halted", 32'(o_halted), 32'd1);
    chk("hold_idle", 32'(o_action), 32'd0);

    // ALU table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      clear_mem();
      mem[0] = ldi(1, vt[i].a);
      mem[1] = ldi(2, vt[i].b);
      mem[2] = ins(vt[i].op, 1, vt[i].rs);
      mem[3] = ldi(3, 9'h080);
      mem[4] = ins(OP_ST, 1, 3);
      mem[5] = ins(OP_HALT, 0, 0);
      run(0, 100, 1'b1, c);
      chk($sformatf("alu%0d_cycles", i), 32'(c), 32'd13);
      chk($sformatf("alu%0d_waddr", i), 32'(qat(wr_addr_q, 0)), 32'h80);
      chk($sformatf("alu%0d_wdata", i), 32'(qat(wr_data_q, 0)), 32'(vt[i].exp));
    end

    // store/load with zero wait states
    do_reset();
    load_ldst();
    run(0, 200, 1'b1, c);
    chk("ldst_cycles", 32'(c), 32'd21);
    chk("ldst_nwr", 32'(wr_addr_q.size()), 32'd2);
    chk("st_addr", 32'(qat(wr_addr_q, 0)), 32'h20);
    chk("st_data", 32'(qat(wr_data_q, 0)), 32'd8);
    chk("ld_st_addr", 32'(qat(wr_addr_q, 1)), 32'h21);
    chk("ld_st_data", 32'(qat(wr_data_q, 1)), 32'd8);
    chk("st_one_cycle", 32'(wr_cycles), 32'd2);
    chk("odata_zero", 32'(odata_err), 32'd0);
    chk("no_rsvd_action", 32'(rsvd_err), 32'd0);

    // same program, three wait states per transfer
    do_reset();
    load_ldst();
    run(3, 400, 1'b1, c);
    chk("stall_cycles", 32'(c), 32'd57);
    chk("stall_stable", 32'(stable_err), 32'd0);
    chk("stall_wr_cycles", 32'(wr_cycles), 32'd8);
    chk("stall_st_data", 32'(qat(wr_data_q, 0)), 32'd8);
    chk("stall_ld_st_data", 32'(qat(wr_data_q, 1)), 32'd8);
    chk("stall_odata_zero", 32'(odata_err), 32'd0);

    // branches
    do_reset();
    clear_mem();
    mem[8'h00] = ldi(5, 9'h040);
    mem[8'h01] = ins(OP_BZ, 0, 5);
    mem[8'h40] = ldi(7, 9'd1);
    mem[8'h41] = ins(OP_BZ, 7, 5);
    mem[8'h42] = ldi(6, 9'h050);
    mem[8'h43] = ins(OP_JMP, 0, 6);
    mem[8'h50] = ins(OP_HALT, 0, 0);
    run(0, 100, 1'b1, c);
    chk("bz_taken", 32'(qat(rd_q, 2)), 32'h40);
    chk("bz_fall", 32'(qat(rd_q, 4)), 32'h42);
    chk("jmp", 32'(qat(rd_q, 6)), 32'h50);
    chk("br_cycles", 32'(c), 32'd14);

    // illegal opcode: reported, sticky, no register change
    do_reset();
    clear_mem();
    mem[0] = ldi(1, 9'd9);
    mem[1] = {4'hB, 3'd1, 3'd1, 6'd0};
    mem[2] = ldi(3, 9'h020);
    mem[3] = ins(OP_ST, 1, 3);
    mem[4] = 16'hE000;
    mem[5] = ins(OP_HALT, 0, 0);
    run(0, 3, 1'b0, c);
    chk("ill_before", 32'(o_illegal), 32'd0);
    run(0, 1, 1'b0, c);
    chk("ill_set", 32'(o_illegal), 32'd1);
    run(0, 100, 1'b1, c);
    chk("ill_rest_cycles", 32'(c), 32'd9);
    chk("ill_regs_kept", 32'(qat(wr_data_q, 0)), 32'd9);
    chk("ill_sticky", 32'(o_illegal), 32'd1);

    // reset during a stalled fetch
    do_reset();
    clear_mem();
    mem[0] = ldi(1, 9'd5);
    mem[1] = ins(OP_HALT, 0, 0);
    run(3, 7, 1'b0, c);
    chk("pre_abort_pc", 32'(o_pc), 32'd1);
    chk("pre_abort_action", 32'(o_action), 32'(ACT_RD));
    #1 rst = 1'b1;
    #1;
    chk("abort_action", 32'(o_action), 32'd0);
    chk("abort_pc", 32'(o_pc), 32'd0);
    chk("abort_addr", 32'(o_addr), 32'd0);
    chk("abort_illegal", 32'(o_illegal), 32'd0);

    // narrow address: PC wraps from 15 to 0
    @(negedge clk);
    chk("w_rst_addr", 32'(o_addr2), 32'd0);
    chk("w_rst_pc", 32'(o_pc2), 32'd15);
    rst2 = 1'b0;
    #1;
    chk("w_fetch_addr", 32'(o_addr2), 32'd15);
    i_ready2 = 1'b1;
    i_data2 = ins(OP_NOP, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("w_pc_wrap", 32'(o_pc2), 32'd0);
    chk("w_exec_idle", 32'(o_action2), 32'd0);
    i_data2 = ins(OP_HALT, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("w_next_fetch", 32'(o_addr2), 32'd0);
    chk("w_next_action", 32'(o_action2), 32'(ACT_RD));
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("w_halted", 32'(o_halted2), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
